// File: rtl/seg7_capture.sv
// Seven-segment bus receiver: synchronizes the scanned bus, debounces each digit and rebuilds
// the displayed 4-digit BCD frame. Define SEG7_CAP_BIN_EN to also build the BCD-to-binary stage.
module seg7_capture #(
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic [0:6]  seg,
    input  logic [3:0]  digit,
    output logic [3:0]  ones,
    output logic [3:0]  tens,
    output logic [3:0]  hundreds,
    output logic [3:0]  thousands,
    output logic [13:0] value,
    output logic        frame_valid,
    output logic        pattern_err
);

    localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CntW-1:0] SettleMax  = CntW'(SETTLE_CYCLES);
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);

`ifdef SEG7_CAP_BIN_EN
    typedef enum logic [1:0] {StIdle, StCollect, StConvert} state_e;
`else
    typedef enum logic [1:0] {StIdle, StCollect} state_e;
`endif

    logic [10:0]     sync1_q, sync2_q, prev_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            word_same, accept;
    logic [3:0]      acc_digit;
    logic [6:0]      acc_seg;
    logic [3:0]      seg_bcd;
    logic            seg_ok;
    logic [3:0]      slot_oh;
    logic            blank;
    logic            acc_valid, acc_bad;
    logic [3:0]      stage_q [4];
    logic [3:0]      seen_q, seen_d;
    state_e          state_q, state_d;
    logic            load_bcd;

    // Input synchronizer plus one-cycle-delayed copy used for change detection
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= {digit, seg};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
        end
    end

    assign word_same = (sync2_q == prev_q);

    always_comb begin
        cnt_d = cnt_q;
        if (!word_same) begin
            cnt_d = '0;
        end else if (cnt_q != SettleMax) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Fires only on the cycle the counter steps onto its saturation value
    assign accept    = word_same && (cnt_q == SettleLast);
    assign acc_digit = sync2_q[10:7];
    assign acc_seg   = sync2_q[6:0];

    always_comb begin
        seg_ok  = 1'b1;
        seg_bcd = 4'd0;
        case (acc_seg)
            7'b0000001: seg_bcd = 4'd0;
            7'b1001111: seg_bcd = 4'd1;
            7'b0010010: seg_bcd = 4'd2;
            7'b0000110: seg_bcd = 4'd3;
            7'b1001100: seg_bcd = 4'd4;
            7'b0100100: seg_bcd = 4'd5;
            7'b0100000: seg_bcd = 4'd6;
            7'b0001111: seg_bcd = 4'd7;
            7'b0000000: seg_bcd = 4'd8;
            7'b0000100: seg_bcd = 4'd9;
            default:    seg_ok  = 1'b0;
        endcase
    end

    always_comb begin
        slot_oh = 4'b0000;
        blank   = 1'b0;
        case (acc_digit)
            4'b1110: slot_oh = 4'b0001;
            4'b1101: slot_oh = 4'b0010;
            4'b1011: slot_oh = 4'b0100;
            4'b0111: slot_oh = 4'b1000;
            4'b1111: blank   = 1'b1;
            default: slot_oh = 4'b0000;
        endcase
    end

    assign acc_valid = accept && (slot_oh != 4'b0000) && seg_ok;
    assign acc_bad   = accept && !blank && !((slot_oh != 4'b0000) && seg_ok);

    always_comb begin
        seen_d = seen_q;
        if (load_bcd) begin
            seen_d = 4'b0000;
        end
        if (acc_valid) begin
            seen_d = seen_d | slot_oh;
        end else if (acc_bad) begin
            seen_d = 4'b0000;
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                stage_q[i] <= 4'd0;
            end
            seen_q      <= 4'b0000;
            pattern_err <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (acc_valid && slot_oh[i]) begin
                    stage_q[i] <= seg_bcd;
                end
            end
            seen_q      <= seen_d;
            pattern_err <= acc_bad;
        end
    end

`ifdef SEG7_CAP_BIN_EN
    logic [1:0]  step_q;
    logic [13:0] acc_q, acc_next;
    logic [3:0]  conv_digit;
    logic        conv_step, conv_done;
`endif

    // Frame FSM: state register
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (acc_valid) begin
                    state_d = StCollect;
                end
            end
            StCollect: begin
                if (seen_q == 4'b1111) begin
`ifdef SEG7_CAP_BIN_EN
                    state_d = StConvert;
`else
                    state_d = StCollect;
`endif
                end
            end
`ifdef SEG7_CAP_BIN_EN
            StConvert: begin
                if (step_q == 2'd3) begin
                    state_d = StCollect;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Frame FSM: control outputs
    always_comb begin
        load_bcd = (state_q == StCollect) && (seen_q == 4'b1111);
`ifdef SEG7_CAP_BIN_EN
        conv_step = (state_q == StConvert);
        conv_done = conv_step && (step_q == 2'd3);
`endif
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            ones      <= 4'd0;
            tens      <= 4'd0;
            hundreds  <= 4'd0;
            thousands <= 4'd0;
        end else if (load_bcd) begin
            ones      <= stage_q[0];
            tens      <= stage_q[1];
            hundreds  <= stage_q[2];
            thousands <= stage_q[3];
        end
    end

`ifdef SEG7_CAP_BIN_EN
    // Most significant digit first, so acc ends as th*1000 + h*100 + t*10 + o
    always_comb begin
        conv_digit = ones;
        case (step_q)
            2'd0:    conv_digit = thousands;
            2'd1:    conv_digit = hundreds;
            2'd2:    conv_digit = tens;
            default: conv_digit = ones;
        endcase
    end

    assign acc_next = (acc_q * 14'd10) + {10'd0, conv_digit};

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            step_q      <= 2'd0;
            acc_q       <= 14'd0;
            value       <= 14'd0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= conv_done;
            if (load_bcd) begin
                step_q <= 2'd0;
                acc_q  <= 14'd0;
            end else if (conv_step) begin
                step_q <= step_q + 2'd1;
                acc_q  <= acc_next;
                if (conv_done) begin
                    value <= acc_next;
                end
            end
        end
    end
`else
    assign value = 14'd0;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= load_bcd;
        end
    end
`endif

endmodule
